// File: rtl/iv_field_merge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iv_field_merge_pkg                                                 |
// | Shared state constants and the byte rotate / length-mask helpers.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package iv_field_merge_pkg;

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_read  = 3'd1;
   localparam logic [2:0] c_st_merge = 3'd2;
   localparam logic [2:0] c_st_write = 3'd3;
   localparam logic [2:0] c_st_fin   = 3'd4;

   // Doubling the byte makes the wrap-around fall out of a plain shift.
   function automatic logic [7:0] rotl8(input logic [7:0] value, input logic [2:0] amount);
      logic [15:0] w_dbl;
      w_dbl = {value, value} << amount;
      return w_dbl[15:8];
   endfunction

   function automatic logic [7:0] len_mask(input logic [2:0] len);
      logic [8:0] w_ones;
      w_ones = (9'd1 << len) - 9'd1;
      return (len == 3'd0) ? 8'hFF : w_ones[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/iv_bus_wait.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iv_bus_wait                                                        |
// | Bus wait counter with timeout compare, shared by READ and WRITE.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iv_bus_wait #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam logic [7:0] c_last = 8'(TIMEOUT - 1);

   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // High during the last request cycle the bus is allowed before abort.
   assign expired = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/iv_field_merge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | iv_field_merge                                                     |
// | Read-modify-write of a rotated bit field into an IV bus byte.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module iv_field_merge
   import iv_field_merge_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] field_in,
   input  logic [2:0] len,
   input  logic [2:0] pos,
   input  logic [7:0] iv_rdata,
   input  logic       iv_ack,
   output logic       iv_req,
   output logic       iv_we,
   output logic [7:0] iv_wdata,
   output logic       busy,
   output logic       done,
   output logic       err
);

   logic [2:0] r_state;
   logic [7:0] r_mask;
   logic [7:0] r_data;
   logic [7:0] r_old;
   logic [7:0] r_wdata;
   logic       r_err;

   logic [7:0] w_mask;
   logic [7:0] w_data;
   logic       w_bus;
   logic       w_expired;

   assign w_mask = rotl8(len_mask(len), pos);
   assign w_data = rotl8(field_in, pos);
   assign w_bus  = (r_state == c_st_read) || (r_state == c_st_write);

   iv_bus_wait #(
      .TIMEOUT (TIMEOUT)
   ) u_bus_wait (
      .clk     (clk),
      .rst     (rst),
      .clr     (!w_bus),
      .inc     (w_bus && !iv_ack),
      .expired (w_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_mask  <= '0;
         r_data  <= '0;
         r_old   <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            c_st_idle: begin
               if (start) begin
                  r_mask <= w_mask;
                  r_data <= w_data;
                  if (w_mask == 8'hFF) begin
                     r_wdata <= w_data;
                     r_state <= c_st_write;
                  end else begin
                     r_state <= c_st_read;
                  end
               end
            end
            c_st_read: begin
               if (iv_ack) begin
                  r_old   <= iv_rdata;
                  r_state <= c_st_merge;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= c_st_idle;
               end
            end
            c_st_merge: begin
               r_wdata <= (r_old & ~r_mask) | (r_data & r_mask);
               r_state <= c_st_write;
            end
            c_st_write: begin
               // Ack takes priority over an expiring wait counter.
               if (iv_ack) begin
                  r_state <= c_st_fin;
               end else if (w_expired) begin
                  r_err   <= 1'b1;
                  r_state <= c_st_idle;
               end
            end
            c_st_fin: begin
               r_state <= c_st_idle;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   assign iv_req   = w_bus;
   assign iv_we    = (r_state == c_st_write);
   assign iv_wdata = r_wdata;
   assign busy     = (r_state != c_st_idle);
   assign done     = (r_state == c_st_fin);
   assign err      = r_err;

endmodule
`default_nettype wire
